multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style controller that sequences the shared datapath (PC register, PC+4 adder, PC/register-address select muxes, ALU, unified memory) over multiple cycles per instruction.
- Decodes the ARM-subset fields of the latched instruction and holds the NZCV flags register.
- Drives every select, enable and ALU control signal of the datapath.
- Sits beside the datapath in the processor top level.

Parameters:
ALUCTL_W, 2, width of ALUControl (00 ADD, 01 SUB, 10 AND, 11 ORR)
STATE_W, 4, width of state register / State debug port

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
Cond  in  4  instruction[31:28]
Op  in  2  instruction[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
Funct  in  6  instruction[25:20]: [5] I, [4:1] cmd, [0] S (or L for memory; [3] U)
Rd  in  4  instruction[15:12]
ALUFlags  in  4  NZCV from ALU, current cycle
PCWrite  out  1  PC register load enable
AdrSrc  out  1  memory address: 0 PC, 1 ALU result register
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
ALUSrcA  out  1  0 register A, 1 PC
ALUSrcB  out  2  00 register B, 01 extended immediate, 10 constant 4
ResultSrc  out  2  00 ALU result register, 01 memory data, 10 ALU output direct
ImmSrc  out  2  equals Op
RegSrc  out  2  [0] A1 mux selects R15; [1] A2 mux selects Rd
ALUControl  out  ALUCTL_W  ALU operation
State  out  STATE_W  current state (debug)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Outputs are decoded from state, except the CondEx and Rd gating noted below.
- Unlisted outputs are 0 in every state.
- Reset:
  - State=FETCH, flags=0000.
  - While RST is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0.
  - Other outputs take their FETCH values.
  - RST asserted mid-instruction aborts it immediately; no partial write completes.
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (PC+8), RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
  - Next, evaluated in order:
    - CondEx=0 -> FETCH.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=00, I=1 -> EXECI.
    - Op=00, I=0 -> EXECR.
    - Op=11 -> FETCH (no side effects).
- CondEx (combinational, from registered flags; evaluates to 1 when):
  - 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V.
  - 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 always.
  - 1111 never.
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ALUControl = U ? ADD : SUB.
  - Next: MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1. Next: MEMWB.
- MEMWB:
  - ResultSrc=01.
  - Rd==15: PCWrite=1, RegWrite=0. Otherwise: RegWrite=1.
  - Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, RegSrc[1]=1. Next: FETCH.
- EXECR / EXECI:
  - ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from cmd: 0100 ADD, 0010 SUB, 1010 SUB (CMP), 0000 AND, 1100 ORR, any other ADD.
  - Next: ALUWB.
  - Flags are captured from ALUFlags at the end of EXECR/EXECI when S=1 or cmd=1010.
- ALUWB:
  - ResultSrc=00.
  - CMP: no register or PC write.
  - Otherwise Rd==15: PCWrite=1, else RegWrite=1.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=0 (R15 via RegSrc[0]=1), ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next: FETCH.
- Latency in cycles:
  - Data-processing 4, LDR 5, STR 4, B 3.
  - Condition-failed or undefined instruction 2.
- Flags change only as stated above.
- A flag update is visible to CondEx of the next instruction's DECODE.

Optional Feature:
- Macro: MULTICYCLE_CTRL_MEM_WAIT_EN.
- Defined:
  - Adds input MemReady (1 bit).
  - FETCH, MEMRD and MEMWR hold their state and outputs until MemReady=1.
  - PCWrite, IRWrite and MemWrite assert only in the cycle MemReady=1.
  - Reset behaviour is unchanged.
- Undefined: no MemReady port; each of these states lasts exactly one cycle.

Test Plan:
- RST high mid-MEMWR, then release -> MemWrite=0 immediately; State=FETCH, flags=0000; first post-reset cycle has IRWrite=1, PCWrite=1.
- ADDS R1,R2,#5 (Cond=1110, Op=00, Funct=101001, Rd=1), ALUFlags=0100 in EXECI -> states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in ALUWB only; flags=0100.
- Flags Z=1, then BNE (Cond=0001) -> FETCH, DECODE, FETCH; PCWrite asserted only in FETCH. Same with BEQ -> BRANCH entered, PCWrite=1 there.
- LDR R15,[R3,#8] with U=0 -> MEMADR ALUControl=SUB; MEMRD AdrSrc=1; MEMWB PCWrite=1, RegWrite=0; 5 cycles total.
- CMP R4,R5 (cmd=1010, S=1), ALUFlags=1000 -> flags=1000, no RegWrite; following LT-conditioned instruction (N!=V) executes.
- With MULTICYCLE_CTRL_MEM_WAIT_EN, MemReady low for 3 cycles in FETCH -> State holds FETCH 4 cycles; IRWrite and PCWrite pulse once, in the 4th.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for the ARM-subset shared datapath: the FSM, the condition check and the
// NZCV flags. Optional memory-wait handshake when MULTICYCLE_CTRL_MEM_WAIT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned ALUCTL_W = 2,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          Cond,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          ALUFlags,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic                MemReady,
`endif
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [STATE_W-1:0]  State
);

  typedef enum logic [STATE_W-1:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex, mem_ready, is_cmp, rd_pc;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic [1:0] alu_ctl, dp_alu;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign is_cmp = (Funct[4:1] == 4'b1010);
  assign rd_pc  = (Rd == 4'd15);

  // flags_q is {N, Z, C, V}
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    unique case (Funct[4:1])
      4'b0010, 4'b1010: dp_alu = AluSub;
      4'b0000:          dp_alu = AluAnd;
      4'b1100:          dp_alu = AluOrr;
      default:          dp_alu = AluAdd;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegSrc    = 2'b00;
    alu_ctl   = AluAdd;
    unique case (state_q)
      StFetch: begin
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        RegSrc  = {Op == 2'b01, Op == 2'b10};
        if (!cond_ex) begin
          state_d = StFetch;
        end else begin
          unique case (Op)
            2'b01:   state_d = StMemAdr;
            2'b10:   state_d = StBranch;
            2'b00:   state_d = Funct[5] ? StExecI : StExecR;
            default: state_d = StFetch;
          endcase
        end
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        alu_ctl = Funct[3] ? AluAdd : AluSub;
        state_d = Funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        pc_write  = rd_pc;
        reg_write = ~rd_pc;
        state_d   = StFetch;
      end
      StMemWr: begin
        AdrSrc    = 1'b1;
        mem_write = mem_ready;
        RegSrc    = 2'b10;
        if (mem_ready) state_d = StFetch;
      end
      StExecR, StExecI: begin
        ALUSrcB = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_ctl = dp_alu;
        if (Funct[0] || is_cmp) flags_d = ALUFlags;
        state_d = StAluWb;
      end
      StAluWb: begin
        pc_write  = ~is_cmp & rd_pc;
        reg_write = ~is_cmp & ~rd_pc;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        RegSrc    = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Strobes are gated directly by RST so an abort takes effect in the same cycle.
  assign PCWrite    = pc_write & ~RST;
  assign IRWrite    = ir_write & ~RST;
  assign RegWrite   = reg_write & ~RST;
  assign MemWrite   = mem_write & ~RST;
  assign ImmSrc     = Op;
  assign ALUControl = ALUCTL_W'(alu_ctl);
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a vector table of whole instructions, hand sequences for reset and
// memory-wait corners, and random instructions against a per-instruction cycle model.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic       MemReady = 1'b1;
`endif

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 CLK = ~CLK;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw, srca;
    logic [1:0] srcb, res, regsrc, aluc;
  } obs_t;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] af;
    int         len, rw, pw, mw;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_flags;
  obs_t       exp_q[$];
  vec_t       vecs[13];
  obs_t       rst_obs;

  function automatic obs_t dut_obs();
    return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc,
            RegSrc, ALUControl};
  endfunction

  function automatic obs_t mk(logic [3:0] st, logic pcw, logic adr, logic memw, logic irw,
                              logic regw, logic srca, logic [1:0] srcb, logic [1:0] res,
                              logic [1:0] regsrc, logic [1:0] aluc);
    obs_t o;
    o = '{st, pcw, adr, memw, irw, regw, srca, srcb, res, regsrc, aluc};
    return o;
  endfunction

  // ARM-style: even codes test a base condition, odd codes are its inverse.
  function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [1:0] dp_alu(logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  // Expected per-cycle outputs of one whole instruction.
  task automatic build(logic [3:0] cond, logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                       logic [3:0] flags);
    logic wb;
    exp_q.delete();
    exp_q.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00));
    exp_q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, {op == 2'b01, op == 2'b10},
                       2'b00));
    if (!cond_ok(cond, flags) || op == 2'b11) return;
    case (op)
      2'b01: begin
        exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00,
                           funct[3] ? 2'b00 : 2'b01));
        if (funct[0]) begin
          exp_q.push_back(mk(S_MEMRD, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
          exp_q.push_back(mk(S_MEMWB, rd == 15, 0, 0, 0, rd != 15, 0, 2'b00, 2'b01, 2'b00,
                             2'b00));
        end else begin
          exp_q.push_back(mk(S_MEMWR, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00));
        end
      end
      2'b10: exp_q.push_back(mk(S_BRANCH, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b00));
      default: begin
        wb = (funct[4:1] != 4'b1010);
        exp_q.push_back(mk(funct[5] ? S_EXECI : S_EXECR, 0, 0, 0, 0, 0, 0,
                           funct[5] ? 2'b01 : 2'b00, 2'b00, 2'b00, dp_alu(funct[4:1])));
        exp_q.push_back(mk(S_ALUWB, wb && rd == 15, 0, 0, 0, wb && rd != 15, 0, 2'b00, 2'b00,
                           2'b00, 2'b00));
      end
    endcase
  endtask

  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, expv);
    end
  endtask

  // Runs up to ncyc cycles of an instruction, checking every cycle against the model.
  task automatic run_instr(string nm, logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                           logic [3:0] rd, bit rnd, logic [3:0] af, int ncyc);
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    build(cond, op, funct, rd, m_flags);
    for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
      ALUFlags = rnd ? 4'($urandom) : af;
      @(negedge CLK);
      chk(nm, i, 32'(dut_obs()), 32'(exp_q[i]));
      if (exp_q[i].st inside {S_MEMADR, S_EXECI, S_BRANCH}) chk({nm, "_imm"}, i, 32'(ImmSrc), 32'(op));
      if ((exp_q[i].st == S_EXECR || exp_q[i].st == S_EXECI) &&
          (funct[0] || funct[4:1] == 4'b1010)) m_flags = ALUFlags;
      @(posedge CLK); #1;
    end
  endtask

  task automatic measure(vec_t v, int idx);
    int n, rw, pw, mw;
    Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.af;
    n = 0; rw = 0; pw = 0; mw = 0;
    do begin
      @(negedge CLK);
      rw += int'(RegWrite); pw += int'(PCWrite); mw += int'(MemWrite);
      n++;
      @(posedge CLK); #1;
    end while (State != S_FETCH && n < 12);
    chk("vec_len", idx, n, v.len);
    chk("vec_regwrite", idx, rw, v.rw);
    chk("vec_pcwrite", idx, pw, v.pw);
    chk("vec_memwrite", idx, mw, v.mw);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, 4, 1, 1, 0};  // ADDS, Z=1
    vecs[1]  = '{4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 2, 0, 1, 0};  // BNE skipped
    vecs[2]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 0, 2, 0};  // BEQ taken
    vecs[3]  = '{4'hE, 2'b01, 6'b010001, 4'd15, 4'b0000, 5, 0, 2, 0};  // LDR PC
    vecs[4]  = '{4'hE, 2'b01, 6'b011000, 4'd2,  4'b0000, 4, 0, 1, 1};  // STR
    vecs[5]  = '{4'hE, 2'b00, 6'b010101, 4'd0,  4'b1000, 4, 0, 1, 0};  // CMP, N=1
    vecs[6]  = '{4'hB, 2'b00, 6'b001000, 4'd3,  4'b0000, 4, 1, 1, 0};  // ADDLT runs
    vecs[7]  = '{4'hA, 2'b00, 6'b001000, 4'd3,  4'b0000, 2, 0, 1, 0};  // ADDGE skipped
    vecs[8]  = '{4'hE, 2'b11, 6'b000000, 4'd3,  4'b0000, 2, 0, 1, 0};  // undefined op
    vecs[9]  = '{4'hF, 2'b00, 6'b001000, 4'd3,  4'b0000, 2, 0, 1, 0};  // never
    vecs[10] = '{4'hE, 2'b00, 6'b000101, 4'd15, 4'b0000, 4, 0, 2, 0};  // SUBS PC, flags 0
    vecs[11] = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 2, 0, 1, 0};  // BEQ skipped
    vecs[12] = '{4'hE, 2'b00, 6'b111000, 4'd5,  4'b1111, 4, 1, 1, 0};  // ORR imm, no S
    rst_obs = mk(S_FETCH, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00);

    Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    RST = 1'b1;
    @(negedge CLK);
    chk("reset_outputs", 0, 32'(dut_obs()), 32'(rst_obs));
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 13; i++) measure(vecs[i], i);

    m_flags = 4'b0000;
    run_instr("adds", 4'hE, 2'b00, 6'b101001, 4'd1, 0, 4'b0100, 99);
    run_instr("bne_z", 4'h1, 2'b10, 6'd0, 4'd0, 0, 4'b0000, 99);
    run_instr("beq_z", 4'h0, 2'b10, 6'd0, 4'd0, 0, 4'b0000, 99);

    // Abort a store in MEMWR with Z=1 still set.
    run_instr("str_pre", 4'hE, 2'b01, 6'b011000, 4'd2, 0, 4'b0000, 3);
    @(negedge CLK);
    chk("memwr_before_rst", 0, 32'(MemWrite), 32'd1);
    #1 RST = 1'b1;
    #1 chk("rst_mid_memwr", 0, 32'(dut_obs()), 32'(rst_obs));
    @(posedge CLK); #1;
    RST = 1'b0;
    m_flags = 4'b0000;
    run_instr("beq_after_rst", 4'h0, 2'b10, 6'd0, 4'd0, 0, 4'b0000, 99);

    run_instr("ldr_pc_sub", 4'hE, 2'b01, 6'b010001, 4'd15, 0, 4'b0000, 99);
    run_instr("cmp", 4'hE, 2'b00, 6'b010101, 4'd0, 0, 4'b1000, 99);
    run_instr("addlt", 4'hB, 2'b00, 6'b001000, 4'd3, 0, 4'b0000, 99);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    Cond = 4'hE; Op = 2'b11; Funct = 6'd0; Rd = 4'd0;
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("wait_fetch_state", i, 32'(State), 32'(S_FETCH));
      chk("wait_fetch_strobes", i, 32'({IRWrite, PCWrite}), 32'd0);
      @(posedge CLK); #1;
    end
    MemReady = 1'b1;
    @(negedge CLK);
    chk("wait_fetch_release", 0, 32'({State, IRWrite, PCWrite}), 32'({S_FETCH, 2'b11}));
    @(posedge CLK); #1;
    chk("wait_to_decode", 0, 32'(State), 32'(S_DECODE));
    @(posedge CLK); #1;
`endif

    for (int n = 0; n < 200; n++) begin
      logic [3:0] c, r;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr("rand", c, 2'($urandom), 6'($urandom), r, 1, 4'b0000, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
